// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD read and write controllers.
// Timing defaults assume a 50 MHz clock.
package lcd_pkg;

    localparam int unsigned T_AS  = 3;
    localparam int unsigned T_PW  = 15;
    localparam int unsigned T_H   = 2;
    localparam int unsigned T_REC = 5;

    localparam int unsigned BF_BIT = 7;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnHi,
        StHold,
        StRecover,
        StDone
    } lcd_rd_state_e;

    // Bits needed to hold (longest phase - 1) in the phase down-counter.
    function automatic int unsigned dur_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lcd_sync2.sv
// 8-bit two-flop synchronizer for the asynchronous LCD data pins.
module lcd_sync2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);

    logic [7:0] r_meta;
    logic [7:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 8'h00;
            r_sync <= 8'h00;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle controller: single BF/AC or RAM reads, plus bounded busy-flag polling.
// All LCD pins and status outputs come straight from registers.
module lcd_read_ctrl #(
    parameter int unsigned T_AS     = lcd_pkg::T_AS,
    parameter int unsigned T_PW     = lcd_pkg::T_PW,
    parameter int unsigned T_H      = lcd_pkg::T_H,
    parameter int unsigned T_REC    = lcd_pkg::T_REC,
    parameter int unsigned POLL_MAX = 2000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ,
    input  logic       iRS,
    input  logic       iPOLL,
    output logic       oBUSY,
    output logic       oVALID,
    output logic [7:0] oDATA,
    output logic       oTIMEOUT,
    output logic       oBUS_OWN,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    import lcd_pkg::*;

    localparam int unsigned DUR_W  = dur_width(T_AS, T_PW, T_H, T_REC);
    localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);

    localparam logic [DUR_W-1:0]  LD_AS    = DUR_W'(T_AS - 1);
    localparam logic [DUR_W-1:0]  LD_PW    = DUR_W'(T_PW - 1);
    localparam logic [DUR_W-1:0]  LD_H     = DUR_W'(T_H - 1);
    localparam logic [DUR_W-1:0]  LD_REC   = DUR_W'(T_REC - 1);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(POLL_MAX);

    lcd_rd_state_e     r_state;
    logic [DUR_W-1:0]  r_dur;
    logic [PCNT_W-1:0] r_pcnt;
    logic              r_poll;
    logic [7:0]        r_cap;
    logic              r_busy;
    logic              r_valid;
    logic [7:0]        r_data;
    logic              r_timeout;
    logic              r_own;
    logic              r_rw;
    logic              r_en;
    logic              r_rs;
    logic [7:0]        w_sync;

    lcd_sync2 u_sync (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_d   (LCD_DATA_IN),
        .o_q   (w_sync)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= StIdle;
            r_dur     <= '0;
            r_pcnt    <= '0;
            r_poll    <= 1'b0;
            r_cap     <= 8'h00;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_timeout <= 1'b0;
            r_own     <= 1'b0;
            r_rw      <= 1'b0;
            r_en      <= 1'b0;
            r_rs      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (iREQ) begin
                        r_poll  <= iPOLL & (iRS == RS_CMD);
                        r_pcnt  <= '0;
                        r_busy  <= 1'b1;
                        r_own   <= 1'b1;
                        r_rw    <= 1'b1;
                        r_rs    <= iRS;
                        r_dur   <= LD_AS;
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    if (r_dur == '0) begin
                        r_en    <= 1'b1;
                        r_dur   <= LD_PW;
                        r_state <= StEnHi;
                    end else begin
                        r_dur <= r_dur - 1'b1;
                    end
                end
                StEnHi: begin
                    if (r_dur == '0) begin
                        r_en    <= 1'b0;
                        r_cap   <= w_sync;
                        if (r_pcnt != PCNT_MAX) r_pcnt <= r_pcnt + 1'b1;
                        r_dur   <= LD_H;
                        r_state <= StHold;
                    end else begin
                        r_dur <= r_dur - 1'b1;
                    end
                end
                StHold: begin
                    if (r_dur == '0) begin
                        r_rw    <= 1'b0;
                        r_rs    <= 1'b0;
                        r_dur   <= LD_REC;
                        r_state <= StRecover;
                    end else begin
                        r_dur <= r_dur - 1'b1;
                    end
                end
                StRecover: begin
                    if (r_dur != '0) begin
                        r_dur <= r_dur - 1'b1;
                    end else if (r_poll && r_cap[BF_BIT] && (r_pcnt < PCNT_MAX)) begin
                        // Still busy: start another BF read without releasing the bus.
                        r_rw    <= 1'b1;
                        r_rs    <= RS_CMD;
                        r_dur   <= LD_AS;
                        r_state <= StSetup;
                    end else begin
                        r_data    <= r_cap;
                        r_timeout <= r_poll & r_cap[BF_BIT];
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_own     <= 1'b0;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign oBUSY    = r_busy;
    assign oVALID   = r_valid;
    assign oDATA    = r_data;
    assign oTIMEOUT = r_timeout;
    assign oBUS_OWN = r_own;
    assign LCD_RW   = r_rw;
    assign LCD_EN   = r_en;
    assign LCD_RS   = r_rs;

endmodule
